// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the piso_serializer block.
//   piso_state_t     FSM encoding (IDLE, SHIFT, PARITY)
//   IDLE_STATE_RESET state entered on reset and on any illegal encoding
// PARITY is only reachable when PISO_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam piso_state_t IDLE_STATE_RESET = IDLE;

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: counts the data bits presented in the current frame.
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset, clears the count
//   clr  in   clear to 0 (new frame)
//   inc  in   advance by one
//   cnt  out  current count, 0..WIDTH
//   tc   out  terminal count, high when cnt == WIDTH
// The count saturates at WIDTH, so it never wraps.
module piso_bit_counter #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc  = (cnt_q == CW'(WIDTH));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !tc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shifter for the UART TX path.
// A WIDTH-bit word is accepted over valid/ready and shifted out one bit per
// shift_en strobe; data_out is registered and idles at IDLE_LEVEL.
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset (priority over everything)
//   load_valid  in   data_in holds a word to send
//   load_ready  out  word can be accepted (IDLE, not in the done cycle)
//   data_in     in   parallel word, sampled on load_valid && load_ready
//   shift_en    in   bit-advance strobe, ignored in IDLE
//   data_out    out  serial output
//   busy        out  frame in progress
//   done        out  one-cycle pulse at end of frame
// Build option: define PISO_PARITY_EN to append a parity bit
// (sense chosen by PARITY_ODD) after the last data bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             data_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  piso_state_t     state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic            data_out_q, data_out_d;
  logic            done_q, done_d;
  logic            cnt_clr, cnt_inc, cnt_tc;
  logic [CW-1:0]   cnt_val;
  logic            next_bit;
  logic [WIDTH-1:0] sreg_shifted;

`ifdef PISO_PARITY_EN
  logic            parity_q, parity_d;
`endif

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt_val),
    .tc  (cnt_tc)
  );

  // Ready is held low in the done cycle so a back-to-back load lands one
  // clk after done; it is also low while rst is asserted.
  assign load_ready = (state_q == IDLE) && !done_q && !rst;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign data_out   = data_out_q;

  // Outgoing end of the register and the zero-filled shift toward it.
  assign next_bit     = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
  assign sreg_shifted = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]}
                                  : {sreg_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        data_out_d = IDLE_LEVEL;
        if (load_valid && load_ready) begin
          sreg_d  = data_in;
          cnt_clr = 1'b1;
          state_d = SHIFT;
`ifdef PISO_PARITY_EN
          parity_d = (^data_in) ^ PARITY_ODD;
`endif
        end
      end

      SHIFT: begin
        if (shift_en) begin
          if (cnt_tc) begin
`ifdef PISO_PARITY_EN
            data_out_d = parity_q;
            state_d    = PARITY;
`else
            data_out_d = IDLE_LEVEL;
            done_d     = 1'b1;
            state_d    = IDLE;
`endif
          end else begin
            data_out_d = next_bit;
            sreg_d     = sreg_shifted;
            cnt_inc    = 1'b1;
          end
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        if (shift_en) begin
          data_out_d = IDLE_LEVEL;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
`endif

      default: begin
        // Unreachable encodings recover to idle without a done pulse.
        data_out_d = IDLE_LEVEL;
        state_d    = IDLE_STATE_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE_STATE_RESET;
      sreg_q     <= '0;
      data_out_q <= IDLE_LEVEL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule
